// File: rtl/sum_display_driver.sv
// sum_display_driver
//
// Display stage behind the 4-bit adder. On a load strobe it captures the
// 5-bit result V = {cout_in, sum_in} (0..31). A sequential double-dabble
// engine turns V into two BCD digits, one step per cycle over five cycles.
// The digits then drive a two-digit, time-multiplexed, common-anode 7-segment
// display. When the tens digit is zero, that digit is blanked.
//
// Parameters
//   REFRESH_DIV     clock cycles each digit stays lit (2..2^20)
//   ACTIVE_LOW_SEG  1: segments active-low, 0: active-high (seg inverted)
//
// Ports
//   clk      system clock, rising-edge
//   rst_n    asynchronous active-low reset
//   load     capture request; ignored while busy
//   sum_in   adder Sum_total
//   cout_in  adder carry out (MSB of the captured value)
//   busy     high while a conversion is in progress
//   seg      segments {g,f,e,d,c,b,a}, registered
//   an       digit enables, active-low, registered; an[0]=units, an[1]=tens

module sum_display_driver #(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          ACTIVE_LOW_SEG = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] sum_in,
  input  logic       cout_in,
  output logic       busy,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int unsigned    CntW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(REFRESH_DIV - 1);
  localparam logic [2:0]     LastStep = 3'd4;
  // XOR mask that turns the active-low code table into the configured polarity.
  localparam logic [6:0]     SegInv   = ACTIVE_LOW_SEG ? 7'b0000000 : 7'b1111111;
  localparam logic [6:0]     SegZero  = 7'b1000000 ^ SegInv;

  typedef enum logic [0:0] {StIdle, StConvert} state_e;

  // Active-low 7-segment code. Codes 10..15 cannot come out of the converter,
  // so they share the blank pattern.
  function automatic logic [6:0] enc_low(input logic [3:0] digit, input logic blank);
    logic [6:0] code;
    code = 7'b1111111;
    if (!blank) begin
      case (digit)
        4'd0:    code = 7'b1000000;
        4'd1:    code = 7'b1111001;
        4'd2:    code = 7'b0100100;
        4'd3:    code = 7'b0110000;
        4'd4:    code = 7'b0011001;
        4'd5:    code = 7'b0010010;
        4'd6:    code = 7'b0000010;
        4'd7:    code = 7'b1111000;
        4'd8:    code = 7'b0000000;
        4'd9:    code = 7'b0010000;
        default: code = 7'b1111111;
      endcase
    end
    return code;
  endfunction

  // ---------------------------------------------------------------------------
  // Conversion FSM and double-dabble datapath
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [4:0] val_q, val_d;      // remaining bits of V, consumed MSB first
  logic [7:0] bcd_q, bcd_d;      // {tens, units} scratch
  logic [2:0] step_q, step_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;

  logic [7:0] bcd_adj;
  logic [7:0] bcd_shift;

  always_comb begin
    bcd_adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
    bcd_shift = {bcd_adj[6:0], val_q[4]};
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    bcd_d   = bcd_q;
    step_d  = step_q;
    tens_d  = tens_q;
    units_d = units_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          state_d = StConvert;
          val_d   = {cout_in, sum_in};
          bcd_d   = '0;
          step_d  = '0;
        end
      end
      StConvert: begin
        bcd_d  = bcd_shift;
        val_d  = {val_q[3:0], 1'b0};
        step_d = step_q + 3'd1;
        if (step_q == LastStep) begin
          state_d = StIdle;
          // Both digits commit together from the final step, never partially.
          tens_d  = bcd_shift[7:4];
          units_d = bcd_shift[3:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      val_q   <= '0;
      bcd_q   <= '0;
      step_q  <= '0;
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      bcd_q   <= bcd_d;
      step_q  <= step_d;
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign busy = (state_q == StConvert);

  // ---------------------------------------------------------------------------
  // Refresh scan, free-running and independent of the FSM
  // ---------------------------------------------------------------------------
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sel_q, sel_d;   // 0: units, 1: tens
  logic            wrap;
  logic [6:0]      seg_q, seg_d;
  logic [1:0]      an_q, an_d;
  logic [3:0]      scan_digit;
  logic            scan_blank;

  always_comb begin
    wrap  = (cnt_q == CntMax);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    sel_d = sel_q ^ wrap;
    // seg/an are built from the next select so both switch on the same edge.
    scan_digit = sel_d ? tens_q : units_q;
    scan_blank = sel_d && (tens_q == 4'd0);
    seg_d      = enc_low(scan_digit, scan_blank) ^ SegInv;
    an_d       = sel_d ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sel_q <= 1'b0;
      seg_q <= SegZero;
      an_q  <= 2'b10;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_sum_display_driver.sv
module tb_sum_display_driver;

  localparam int Div = 4;
  localparam logic [6:0] Blank = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] sum_in = 4'd0;
  logic       cout_in = 1'b0;
  logic       busy, busy_hi;
  logic [6:0] seg, seg_hi;
  logic [1:0] an, an_hi;

  always #5 clk = ~clk;

  sum_display_driver #(.REFRESH_DIV(Div), .ACTIVE_LOW_SEG(1'b1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .sum_in  (sum_in),
    .cout_in (cout_in),
    .busy    (busy),
    .seg     (seg),
    .an      (an)
  );

  sum_display_driver #(.REFRESH_DIV(Div), .ACTIVE_LOW_SEG(1'b0)) dut_hi (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .sum_in  (sum_in),
    .cout_in (cout_in),
    .busy    (busy_hi),
    .seg     (seg_hi),
    .an      (an_hi)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [10];

  // Reference model: cycles since reset, accepted load edge, display digits.
  int n;
  int k;
  bit active;
  int pv;
  int disp_t, disp_u;
  int commit_n;

  typedef struct {
    logic [3:0] sum;
    logic       cout;
    logic [6:0] exp_u;
    logic [6:0] exp_t;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, n, got, exp);
    end
  endtask

  task automatic model_reset();
    n        = 0;
    k        = -100;
    active   = 1'b0;
    pv       = 0;
    disp_t   = 0;
    disp_u   = 0;
    commit_n = -100;
  endtask

  function automatic logic [6:0] exp_seg_fn();
    if (((n / Div) % 2) == 1) return (disp_t == 0) ? Blank : seg_tab[disp_t];
    return seg_tab[disp_u];
  endfunction

  task automatic step();
    bit         acc;
    logic [1:0] exp_an;
    logic [6:0] es, es_hi;
    @(posedge clk);
    n++;
    acc = load && !active;
    if (active && (n - k == 5)) begin
      disp_t   = pv / 10;
      disp_u   = pv % 10;
      active   = 1'b0;
      commit_n = n;
    end
    if (acc) begin
      k      = n;
      pv     = int'({cout_in, sum_in});
      active = 1'b1;
    end
    #1;
    exp_an = (((n / Div) % 2) == 1) ? 2'b01 : 2'b10;
    chk("busy", 8'(busy), 8'(active));
    chk("busy_hi", 8'(busy_hi), 8'(active));
    chk("an", 8'(an), 8'(exp_an));
    chk("an_hi", 8'(an_hi), 8'(exp_an));
    // Allow the one-cycle lag between digit registers and seg.
    if (n - commit_n >= 2) begin
      es    = exp_seg_fn();
      es_hi = ~es;
      chk("seg", 8'(seg), 8'(es));
      chk("seg_hi", 8'(seg_hi), 8'(es_hi));
    end
  endtask

  task automatic capture(output logic [6:0] gu, output logic [6:0] gt);
    gu = 7'bx;
    gt = 7'bx;
    for (int i = 0; i < 16; i++) begin
      step();
      if (an == 2'b10) gu = seg;
      if (an == 2'b01) gt = seg;
    end
  endtask

  task automatic do_load(input logic [3:0] s, input logic c);
    sum_in  = s;
    cout_in = c;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  initial begin
    logic [6:0] gu, gt;

    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    vecs[0] = '{sum: 4'b0011, cout: 1'b1, exp_u: 7'b0010000, exp_t: 7'b1111001}; // 19
    vecs[1] = '{sum: 4'b0111, cout: 1'b1, exp_u: 7'b0110000, exp_t: 7'b0100100}; // 23
    vecs[2] = '{sum: 4'b0111, cout: 1'b0, exp_u: 7'b1111000, exp_t: 7'b1111111}; // 7
    vecs[3] = '{sum: 4'b1111, cout: 1'b1, exp_u: 7'b1111001, exp_t: 7'b0110000}; // 31
    vecs[4] = '{sum: 4'b1010, cout: 1'b0, exp_u: 7'b1000000, exp_t: 7'b1111001}; // 10
    vecs[5] = '{sum: 4'b0000, cout: 1'b0, exp_u: 7'b1000000, exp_t: 7'b1111111}; // 0
    vecs[6] = '{sum: 4'b1100, cout: 1'b1, exp_u: 7'b0000000, exp_t: 7'b0100100}; // 28

    model_reset();
    #12;
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_an", 8'(an), 8'(2'b10));
    chk("rst_seg", 8'(seg), 8'(7'b1000000));
    chk("rst_seg_hi", 8'(seg_hi), 8'(7'b0111111));
    #1 rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 6; i++) step();

    // Table-driven conversions
    for (int v = 0; v < 7; v++) begin
      do_load(vecs[v].sum, vecs[v].cout);
      capture(gu, gt);
      chk($sformatf("vec%0d_units", v), 8'(gu), 8'(vecs[v].exp_u));
      chk($sformatf("vec%0d_tens", v), 8'(gt), 8'(vecs[v].exp_t));
    end

    // Load during busy is ignored
    do_load(4'b0011, 1'b1);
    step();
    do_load(4'b0101, 1'b0);
    capture(gu, gt);
    chk("ignored_units", 8'(gu), 8'(7'b0010000));
    chk("ignored_tens", 8'(gt), 8'(7'b1111001));

    // Reset mid-conversion aborts and shows 0
    do_load(4'b1111, 1'b1);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_an", 8'(an), 8'(2'b10));
    chk("abort_seg", 8'(seg), 8'(7'b1000000));
    #1 rst_n = 1'b1;
    model_reset();
    capture(gu, gt);
    chk("abort_units", 8'(gu), 8'(7'b1000000));
    chk("abort_tens", 8'(gt), 8'(Blank));

    // Load held high: back-to-back conversions
    load = 1'b1;
    for (int i = 0; i < 30; i++) begin
      sum_in  = 4'($urandom);
      cout_in = 1'($urandom);
      step();
    end
    load = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      load    = ($urandom % 4) == 0;
      sum_in  = 4'($urandom);
      cout_in = 1'($urandom);
      step();
    end
    load = 1'b0;
    for (int i = 0; i < 12; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
